// File: rtl/checksum_scheduler_if.sv
// Shared flit/checksum types plus the requester/consumer bundle of the checksum scheduler.
// No logic here: types and wires only, so there is no latency of its own.
// Flow control is valid/ready on the request side and on the response side.

package types;
  typedef logic [7:0] checksum_t;

  typedef struct packed {
    logic [7:0]  header;
    logic [15:0] payload;
    checksum_t   checksum;
  } flit_t;
endpackage

interface checksum_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  // Request side, one lane per port
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_mode;
  types::flit_t [NUM_REQ-1:0] req_flit;
  logic [NUM_REQ-1:0]         req_ready;

  // Response side, shared by all ports
  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  types::flit_t               resp_flit;
  types::checksum_t           resp_checksum;
  logic                       resp_is_valid;

  // Port logic / link layer side
  modport master (
    output req_valid, req_mode, req_flit, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_flit, resp_checksum, resp_is_valid
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_mode, req_flit, resp_ready,
    output req_ready, resp_valid, resp_id, resp_flit, resp_checksum, resp_is_valid
  );
endinterface

// File: rtl/checksum_scheduler.sv
// Round-robin share of one serial XOR-fold checksum engine between NUM_REQ ports.
// Latency: accept at T, result valid from T+NUM_WORDS+1; one job per NUM_WORDS+2 cycles.
// Backpressure: resp_ready low holds RESP with frozen outputs; req_ready is 0 outside IDLE.

module checksum_scheduler #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  checksum_scheduler_if.slave  bus,
  output logic                 busy
);

  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int W         = $bits(types::checksum_t);
  localparam int HP_W      = $bits(types::flit_t) - W;   // {header, payload}
  localparam int NUM_WORDS = (HP_W + W - 1) / W;
  localparam int IDX_W     = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  types::checksum_t   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  types::flit_t       flit_q, flit_d;
  logic               mode_q, mode_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [NUM_WORDS*W-1:0] padded;
  types::checksum_t   word;

  // Round-robin pick: first valid port starting just after the last served one
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant_q) + off) % NUM_REQ;
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Current engine word: {header, payload} zero-extended to a whole number of words
  always_comb begin
    padded           = '0;
    padded[HP_W-1:0] = {flit_q.header, flit_q.payload};
    word             = padded[int'(idx_q)*W +: W];
  end

  // Next-state logic of the IDLE -> COMPUTE -> RESP job sequence
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    flit_d       = flit_q;
    mode_d       = mode_q;
    id_d         = id_q;
    req_ready_c  = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          flit_d  = bus.req_flit[grant_idx];
          mode_d  = bus.req_mode[grant_idx];
          id_d    = grant_idx;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = acc_q ^ word;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Job state registers; reset leaves port 0 with first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      acc_q        <= '0;
      idx_q        <= '0;
      flit_q       <= '0;
      mode_q       <= 1'b0;
      id_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      flit_q       <= flit_d;
      mode_q       <= mode_d;
      id_q         <= id_d;
    end
  end

  // Outputs: response fields only driven in RESP so idle/reset reads back all zero;
  // the accept strobe is also masked while reset is asserted
  always_comb begin
    bus.req_ready     = rst_n ? req_ready_c : '0;
    busy              = (state_q != IDLE);
    bus.resp_valid    = 1'b0;
    bus.resp_id       = '0;
    bus.resp_flit     = '0;
    bus.resp_checksum = '0;
    bus.resp_is_valid = 1'b0;
    if (state_q == RESP) begin
      bus.resp_valid    = 1'b1;
      bus.resp_id       = id_q;
      bus.resp_checksum = acc_q;
      if (mode_q) begin
        bus.resp_flit     = flit_q;
        bus.resp_is_valid = (acc_q == flit_q.checksum);
      end else begin
        bus.resp_flit     = '{header: flit_q.header, payload: flit_q.payload, checksum: acc_q};
        bus.resp_is_valid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_checksum_scheduler.sv
// Directed bench for checksum_scheduler with 4 ports and 8-bit checksums (3 words/job).
// Inputs change and outputs are sampled 1 ns after the falling edge.
// Each scenario task carries its own hand-computed expectations.

module tb_checksum_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  checksum_scheduler_if #(.NUM_REQ(4)) bus();

  checksum_scheduler #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Advance until resp_valid is seen or the budget runs out
  task automatic wait_resp(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid  = '0;
    bus.req_mode   = '0;
    bus.req_flit   = '0;
    bus.resp_ready = 1'b0;
    tick();
    total++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_flit, bus.resp_checksum,
         bus.resp_is_valid, busy, bus.req_ready} !== '0)
      $display("FAIL reset_outputs: valid=%b id=%0d flit=%h chk=%h isv=%b busy=%b rdy=%b, all required 0",
               bus.resp_valid, bus.resp_id, bus.resp_flit, bus.resp_checksum,
               bus.resp_is_valid, busy, bus.req_ready);
    if ({bus.resp_valid, bus.resp_id, bus.resp_flit, bus.resp_checksum,
         bus.resp_is_valid, busy, bus.req_ready} !== '0) bad++;
    bus.req_valid = '1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ready: req_ready=%b required 0000", bus.req_ready);
    end
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_generate();
    bus.req_valid   = 4'b0001;
    bus.req_mode[0] = 1'b0;
    bus.req_flit[0] = 32'h1234_5600;
    bus.resp_ready  = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL gen_grant: req_ready=%b required 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    #1;
    total++;
    if (busy !== 1'b1 || bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL gen_compute: busy=%b valid=%b rdy=%b required 1 0 0000",
               busy, bus.resp_valid, bus.req_ready);
    end
    tick();
    tick();
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL gen_early: resp_valid=%b at T+3 required 0", bus.resp_valid);
    end
    tick();
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_checksum !== 8'h70 ||
        bus.resp_flit !== 32'h1234_5670 || bus.resp_is_valid !== 1'b1 || bus.resp_id !== 2'd0) begin
      bad++;
      $display("FAIL gen_result: valid=%b chk=%h flit=%h isv=%b id=%0d required 1 70 12345670 1 0",
               bus.resp_valid, bus.resp_checksum, bus.resp_flit, bus.resp_is_valid, bus.resp_id);
    end
    tick();
    total++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL gen_one_cycle: valid=%b busy=%b required 0 0", bus.resp_valid, busy);
    end
  endtask

  task automatic test_check();
    bit got;
    bus.req_valid   = 4'b0100;
    bus.req_mode[2] = 1'b1;
    bus.req_flit[2] = 32'h1234_5670;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL chk_grant: req_ready=%b required 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    wait_resp(10, got);
    total++;
    if (!got || bus.resp_id !== 2'd2 || bus.resp_is_valid !== 1'b1 ||
        bus.resp_checksum !== 8'h70 || bus.resp_flit !== 32'h1234_5670) begin
      bad++;
      $display("FAIL chk_good: got=%b id=%0d isv=%b chk=%h flit=%h required 1 2 1 70 12345670",
               got, bus.resp_id, bus.resp_is_valid, bus.resp_checksum, bus.resp_flit);
    end
    tick();
    bus.req_valid   = 4'b0100;
    bus.req_flit[2] = 32'h1234_5671;
    #1;
    tick();
    bus.req_valid = '0;
    wait_resp(10, got);
    total++;
    if (!got || bus.resp_id !== 2'd2 || bus.resp_is_valid !== 1'b0 ||
        bus.resp_checksum !== 8'h70 || bus.resp_flit !== 32'h1234_5671) begin
      bad++;
      $display("FAIL chk_bad: got=%b id=%0d isv=%b chk=%h flit=%h required 1 2 0 70 12345671",
               got, bus.resp_id, bus.resp_is_valid, bus.resp_checksum, bus.resp_flit);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int grants[$];
    int times[$];
    bit viol;
    bit got;
    viol  = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      bus.req_mode[p] = 1'b0;
      bus.req_flit[p] = {8'(p), 24'h00_0000};
    end
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 40 && grants.size() < 5; c++) begin
      if (bus.req_ready !== 4'b0000) begin
        if ($countones(bus.req_ready) != 1 || busy !== 1'b0) viol = 1'b1;
        for (int j = 0; j < 4; j++)
          if (bus.req_ready[j] === 1'b1) begin
            grants.push_back(j);
            times.push_back(c);
          end
      end else if (busy !== 1'b1) begin
        viol = 1'b1;
      end
      tick();
    end
    bus.req_valid = '0;
    total++;
    if (grants.size() != 5) begin
      bad++;
      $display("FAIL rr_count: grants=%0d required 5", grants.size());
    end
    for (int k = 0; k < 5; k++) begin
      if (k < grants.size()) begin
        total++;
        if (grants[k] != exp_order[k]) begin
          bad++;
          $display("FAIL rr_order[%0d]: port=%0d required %0d", k, grants[k], exp_order[k]);
        end
      end
    end
    if (times.size() >= 2) begin
      total++;
      if (times[1] - times[0] != 5) begin
        bad++;
        $display("FAIL rr_spacing: cycles=%0d required 5", times[1] - times[0]);
      end
    end
    total++;
    if (viol) begin
      bad++;
      $display("FAIL rr_onehot: req_ready violation=%b required 0", viol);
    end
    wait_resp(10, got);
    tick();
  endtask

  task automatic test_backpressure();
    bit got;
    bit viol;
    types::flit_t cap_flit;
    types::checksum_t cap_chk;
    logic [1:0] cap_id;
    viol = 1'b0;
    bus.resp_ready  = 1'b0;
    bus.req_valid   = 4'b0010;
    bus.req_mode[1] = 1'b0;
    bus.req_flit[1] = 32'hA50F_F000;
    #1;
    total++;
    if (bus.req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL bp_grant: req_ready=%b required 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = '1;
    wait_resp(10, got);
    cap_flit = bus.resp_flit;
    cap_chk  = bus.resp_checksum;
    cap_id   = bus.resp_id;
    total++;
    if (!got || cap_flit !== 32'hA50F_F05A || cap_chk !== 8'h5A || cap_id !== 2'd1) begin
      bad++;
      $display("FAIL bp_result: got=%b flit=%h chk=%h id=%0d required 1 a50ff05a 5a 1",
               got, cap_flit, cap_chk, cap_id);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.resp_valid !== 1'b1 || bus.resp_flit !== cap_flit || bus.resp_checksum !== cap_chk ||
          bus.resp_id !== cap_id || bus.req_ready !== 4'b0000 || busy !== 1'b1) viol = 1'b1;
    end
    total++;
    if (viol) begin
      bad++;
      $display("FAIL bp_stall: instability=%b required 0", viol);
    end
    bus.resp_ready = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL bp_release: busy=%b valid=%b rdy=%b required 0 0 0100",
               busy, bus.resp_valid, bus.req_ready);
    end
    bus.req_valid = '0;
    #1;
  endtask

  task automatic test_withdrawn();
    int nresp;
    logic [1:0] rid;
    types::checksum_t rchk;
    bit spurious;
    nresp = 0; rid = '0; rchk = '0; spurious = 1'b0;
    tick();
    bus.req_valid   = 4'b1010;
    bus.req_mode[3] = 1'b0;
    bus.req_flit[3] = 32'h0F00_0100;
    #1;
    total++;
    if (bus.req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL wd_grant: req_ready=%b required 1000", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    #1;
    for (int c = 0; c < 15; c++) begin
      if (bus.resp_valid === 1'b1) begin
        nresp++;
        rid  = bus.resp_id;
        rchk = bus.resp_checksum;
      end
      if (bus.req_ready !== 4'b0000) spurious = 1'b1;
      tick();
    end
    total++;
    if (nresp != 1 || rid !== 2'd3 || rchk !== 8'h0E || spurious) begin
      bad++;
      $display("FAIL wd_result: nresp=%0d id=%0d chk=%h spurious=%b required 1 3 0e 0",
               nresp, rid, rchk, spurious);
    end
  endtask

  task automatic test_reset_mid();
    int nresp;
    logic [1:0] rid;
    nresp = 0; rid = '0;
    bus.req_valid   = 4'b0100;
    bus.req_mode[2] = 1'b0;
    bus.req_flit[2] = 32'h1234_5600;
    bus.req_mode[0] = 1'b0;
    bus.req_flit[0] = 32'h0000_0100;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL rm_grant: req_ready=%b required 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '1;
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rm_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_flit, bus.resp_checksum,
         bus.resp_is_valid, busy, bus.req_ready} !== '0) begin
      bad++;
      $display("FAIL rm_outputs: valid=%b id=%0d flit=%h chk=%h isv=%b busy=%b rdy=%b, all required 0",
               bus.resp_valid, bus.resp_id, bus.resp_flit, bus.resp_checksum,
               bus.resp_is_valid, busy, bus.req_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rm_priority: req_ready=%b required 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    #1;
    for (int c = 0; c < 15; c++) begin
      if (bus.resp_valid === 1'b1) begin
        nresp++;
        rid = bus.resp_id;
      end
      tick();
    end
    total++;
    if (nresp != 1 || rid !== 2'd0) begin
      bad++;
      $display("FAIL rm_after: nresp=%0d id=%0d required 1 0", nresp, rid);
    end
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check();
    test_round_robin();
    test_backpressure();
    test_withdrawn();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/checksum_scheduler.md
# checksum_scheduler

Shares one serial checksum engine among `NUM_REQ` requesters (router input/output ports) with round-robin arbitration and a valid/ready handshake on both sides. Each request either generates a flit's checksum or checks it. The engine XOR-folds `{header, payload}` one `types::checksum_t`-wide word per cycle. Sits between the port logic and the link layer, and is the sequential checksum path of the NoC.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥1.
- `NUM_WORDS`, derived, not overridable: ceil(($bits(header)+$bits(payload)) / $bits(types::checksum_t)).
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous active-low reset.
- `req_valid` input, NUM_REQ: request pending per port.
- `req_mode` input, NUM_REQ: 0 = generate, 1 = check.
- `req_flit` input, NUM_REQ × types::flit_t: flit per port.
- `req_ready` output, NUM_REQ: one-hot accept strobe.
- `resp_valid` output, 1: result available.
- `resp_ready` input, 1: consumer accepts result.
- `resp_id` output, $clog2(NUM_REQ) (min 1): index of the served port.
- `resp_flit` output, types::flit_t: result flit.
- `resp_checksum` output, types::checksum_t: computed checksum.
- `resp_is_valid` output, 1: checksum match.
- `busy` output, 1: high whenever state ≠ IDLE.

## Operation
- FSM states are IDLE, COMPUTE, RESP.
- **IDLE**
  - Grant goes to the first port with `req_valid` high, searching from `last_grant+1` and wrapping modulo NUM_REQ.
  - `req_ready[grant]` is high combinationally in that same cycle. The handshake completes there.
  - The block latches flit, mode and id, clears `acc` and `idx`, and moves to COMPUTE.
  - With no `req_valid` high, it stays in IDLE and `req_ready` = 0.
- **COMPUTE**
  - Each cycle: `acc ^= word[idx]`, then `idx++`.
  - `word[k]` is bits [k·W +: W] of `{header, payload}`, with W = $bits(checksum_t).
  - The top word is zero-padded at the MSBs.
  - After the NUM_WORDS-th word, the FSM moves to RESP.
- **RESP**
  - `resp_valid` = 1. All `resp_*` outputs stay stable until `resp_ready`.
  - On handshake: `last_grant` ← served id, then return to IDLE.
- **Results**
  - `resp_checksum` = `acc` in both modes.
  - Generate mode: `resp_flit` = {header, payload, acc}, and `resp_is_valid` = 1.
  - Check mode: `resp_flit` = the latched flit unchanged, and `resp_is_valid` = (`acc` == latched flit.checksum).
- **Requester rules**
  - Requesters hold `req_flit`/`req_mode` stable while `req_valid` is high and `req_ready` is low.
  - Deasserting `req_valid` before grant is legal. No state is kept for that port.
  - `req_valid` on any port during COMPUTE/RESP is ignored. `req_ready` is 0 outside IDLE.
- **Reset**
  - State = IDLE, `last_grant` = NUM_REQ-1 (port 0 wins first).
  - `acc`, `idx`, latched flit/mode/id = 0.
  - All outputs are 0: `req_ready`, `resp_valid`, `resp_id`, `resp_flit`, `resp_checksum`, `resp_is_valid`, `busy`.
  - Reset mid-COMPUTE or mid-RESP aborts the job. No response is produced and the flit is lost.

## Timing
- Accept at cycle T (IDLE, `req_ready` high) gives COMPUTE in T+1 … T+NUM_WORDS and `resp_valid` high from T+NUM_WORDS+1.
- Best-case throughput is one job per NUM_WORDS+2 cycles. The mandatory IDLE cycle sits between jobs.
- `resp_ready` held low stalls in RESP indefinitely with no data change. `busy` stays high.
- `resp_ready` high in the first RESP cycle gives exactly a one-cycle `resp_valid`. The next grant can occur on the following cycle.
- All registered outputs change only on the `clk` rising edge, except the asynchronous clear by `rst_n`.

## Test plan
The bench configuration is an 8-bit `checksum_t` and 24-bit `{header, payload}`, which gives NUM_WORDS = 3.

- **Generate:** port 0, mode 0, {header, payload} = 0x123456, accepted at T → `resp_valid` at T+4, `resp_checksum` = 0x70, `resp_flit` = {0x123456, 0x70}, `resp_is_valid` = 1, `resp_id` = 0.
- **Check:** port 2, mode 1, flit {0x123456, 0x70} → `resp_is_valid` = 1. The same flit with checksum 0x71 → `resp_is_valid` = 0, `resp_checksum` = 0x70, `resp_flit` unchanged.
- **Round robin:** all 4 ports request continuously from reset → grant order 0, 1, 2, 3, 0. Only one `req_ready` bit is high at a time, never outside IDLE.
- **Back-pressure:** `resp_ready` = 0 for 10 cycles in RESP → `resp_valid` and data stay stable, `req_ready` = 0 throughout. `resp_ready` = 1 → IDLE next cycle.
- **Withdrawn request:** port 1 drops `req_valid` while port 3 is being served → port 1 is not granted afterwards. No spurious response.
- **Reset mid-job:** `rst_n` low in the second COMPUTE cycle → all outputs 0 immediately. After release, no response for the aborted job, and port 0 has first priority.
